// File: rtl/text_line_buffer_pkg.sv
// Shared definitions for the text line buffer: line length, ASCII constants,
// FSM state encoding and byte classes.
// Ports: none (package text_pkg).
package text_pkg;

    localparam int LINE_LEN = 11;

    localparam logic [7:0] ASCII_NUL         = 8'h00;
    localparam logic [7:0] ASCII_BS          = 8'h08;
    localparam logic [7:0] ASCII_CR          = 8'h0D;
    localparam logic [7:0] ASCII_DIGIT_LO    = 8'h30;
    localparam logic [7:0] ASCII_DIGIT_HI    = 8'h39;
    localparam logic [7:0] ASCII_UPPER_LO    = 8'h41;
    localparam logic [7:0] ASCII_UPPER_HI    = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_LO    = 8'h61;
    localparam logic [7:0] ASCII_LOWER_HI    = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_EDIT,
        ST_FULL
    } line_state_t;

    typedef enum logic [1:0] {
        CLS_PRINT,
        CLS_BS,
        CLS_CR,
        CLS_OTHER
    } byte_class_t;

endpackage

// File: rtl/text_line_buffer_ascii_classify.sv
// Combinational byte classifier for the text line buffer.
// Maps an incoming ASCII byte to a class and the character to store.
// Build option: LOWERCASE_FOLD_EN -- when defined, 'a'-'z' are printable and
// stored as their uppercase form; when undefined they fall into CLS_OTHER.
// Ports:
//   in_data    - offered byte
//   byte_class - PRINT / BS / CR / OTHER
//   char_out   - byte to store for PRINT (case-folded when enabled)
module ascii_classify
    import text_pkg::*;
(
    input  logic [7:0]  in_data,
    output byte_class_t byte_class,
    output logic [7:0]  char_out
);

    always_comb begin
        byte_class = CLS_OTHER;
        char_out   = in_data;
        if ((in_data >= ASCII_DIGIT_LO && in_data <= ASCII_DIGIT_HI) ||
            (in_data >= ASCII_UPPER_LO && in_data <= ASCII_UPPER_HI)) begin
            byte_class = CLS_PRINT;
        end else if (in_data == ASCII_BS) begin
            byte_class = CLS_BS;
        end else if (in_data == ASCII_CR) begin
            byte_class = CLS_CR;
        end
`ifdef LOWERCASE_FOLD_EN
        else if (in_data >= ASCII_LOWER_LO && in_data <= ASCII_LOWER_HI) begin
            byte_class = CLS_PRINT;
            char_out   = in_data - ASCII_CASE_OFFSET;
        end
`endif
    end

endmodule

// File: rtl/text_line_buffer.sv
// Single-line text buffer feeding the glyph renderer.
// Bytes are edited into a working line; the displayed line (character) is
// refreshed from it only on a vsync_tick while edits are pending, so the
// renderer never sees a half-updated line.
// Build option: LOWERCASE_FOLD_EN (see ascii_classify).
// Ports:
//   clk, rst_n        - pixel clock, async active-low reset
//   in_valid/in_data  - offered ASCII byte
//   in_ready          - byte accepted this cycle (low in commit cycles and reset)
//   vsync_tick        - start of vertical blanking, commit point
//   character         - displayed line, 8'h00 = empty slot
//   count/full        - working-line occupancy
//   overflow          - sticky: printable byte dropped on a full line
//
// state    | meaning
// ---------+------------------------------
// ST_EMPTY | count == 0
// ST_EDIT  | 0 < count < LINE_LEN
// ST_FULL  | count == LINE_LEN
module text_line_buffer #(
    parameter int LINE_LEN = text_pkg::LINE_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       vsync_tick,
    output logic [7:0] character [0:LINE_LEN-1],
    output logic [3:0] count,
    output logic       full,
    output logic       overflow
);
    import text_pkg::*;

    localparam logic [3:0] LEN_C = 4'(LINE_LEN);

    logic [7:0]  work_q [0:LINE_LEN-1];
    logic [7:0]  work_d [0:LINE_LEN-1];
    logic [7:0]  char_q [0:LINE_LEN-1];
    logic [7:0]  char_d [0:LINE_LEN-1];
    logic [3:0]  count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        dirty_q, dirty_d;
    logic        ready_q;
    line_state_t state_q, state_d;

    byte_class_t byte_class;
    logic [7:0]  fold_char;
    logic        commit;
    logic        accept;
    logic [3:0]  count_m1;

    ascii_classify u_classify (
        .in_data    (in_data),
        .byte_class (byte_class),
        .char_out   (fold_char)
    );

    // ready_q is low only until the first edge after reset release.
    assign commit   = vsync_tick && dirty_q;
    assign in_ready = ready_q && !commit;
    assign accept   = in_valid && in_ready;
    assign count_m1 = count_q - 4'd1;

    always_comb begin
        work_d     = work_q;
        char_d     = char_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        dirty_d    = dirty_q;

        // Accepts never coincide with a commit, so the snapshot is stable.
        if (commit) begin
            char_d  = work_q;
            dirty_d = 1'b0;
        end

        if (accept) begin
            case (byte_class)
                CLS_PRINT: begin
                    if (count_q < LEN_C) begin
                        work_d[count_q] = fold_char;
                        count_d         = count_q + 4'd1;
                        dirty_d         = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                CLS_BS: begin
                    if (count_q != 4'd0) begin
                        work_d[count_m1] = ASCII_NUL;
                        count_d          = count_m1;
                        dirty_d          = 1'b1;
                    end
                end
                CLS_CR: begin
                    work_d     = '{default: ASCII_NUL};
                    count_d    = 4'd0;
                    overflow_d = 1'b0;
                    dirty_d    = 1'b1;
                end
                default: ;
            endcase
        end

        if (count_d == 4'd0) begin
            state_d = ST_EMPTY;
        end else if (count_d == LEN_C) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_EDIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q     <= '{default: ASCII_NUL};
            char_q     <= '{default: ASCII_NUL};
            count_q    <= 4'd0;
            overflow_q <= 1'b0;
            dirty_q    <= 1'b0;
            ready_q    <= 1'b0;
            state_q    <= ST_EMPTY;
        end else begin
            work_q     <= work_d;
            char_q     <= char_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dirty_q    <= dirty_d;
            ready_q    <= 1'b1;
            state_q    <= state_d;
        end
    end

    assign character = char_q;
    assign count     = count_q;
    assign full      = (state_q == ST_FULL);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_text_line_buffer.sv
module tb_text_line_buffer;

    localparam int LEN = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       vsync_tick = 1'b0;
    logic [7:0] character [0:LEN-1];
    logic [3:0] count;
    logic       full;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    text_line_buffer #(.LINE_LEN(LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .vsync_tick (vsync_tick),
        .character  (character),
        .count      (count),
        .full       (full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: line as a queue ----------------
    logic [7:0] line[$];
    logic [7:0] disp [0:LEN-1];
    bit         m_dirty;
    bit         m_ovf;
    bit         m_rdy;
    logic       last_rdy;

    function automatic bit is_print(input logic [7:0] d);
        bit p;
        p = (d >= 8'h30 && d <= 8'h39) || (d >= 8'h41 && d <= 8'h5A);
`ifdef LOWERCASE_FOLD_EN
        p = p || (d >= 8'h61 && d <= 8'h7A);
`endif
        return p;
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] d);
        return (d >= 8'h61) ? d - 8'h20 : d;
    endfunction

    task automatic model_reset();
        line.delete();
        for (int i = 0; i < LEN; i++) disp[i] = 8'h00;
        m_dirty = 0;
        m_ovf   = 0;
        m_rdy   = 0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit vs);
        bit cm;
        bit acc;
        cm  = vs && m_dirty;
        acc = v && m_rdy && !cm;
        if (cm) begin
            for (int i = 0; i < LEN; i++) disp[i] = (i < line.size()) ? line[i] : 8'h00;
            m_dirty = 0;
        end
        if (acc) begin
            if (is_print(d)) begin
                if (line.size() < LEN) begin
                    line.push_back(fold(d));
                    m_dirty = 1;
                end else begin
                    m_ovf = 1;
                end
            end else if (d == 8'h08) begin
                if (line.size() > 0) begin
                    void'(line.pop_back());
                    m_dirty = 1;
                end
            end else if (d == 8'h0D) begin
                line.delete();
                m_ovf   = 0;
                m_dirty = 1;
            end
        end
        m_rdy = 1;
    endtask

    function automatic logic [87:0] dut_chars();
        logic [87:0] r;
        for (int i = 0; i < LEN; i++) r[i*8 +: 8] = character[i];
        return r;
    endfunction

    function automatic logic [87:0] model_chars();
        logic [87:0] r;
        for (int i = 0; i < LEN; i++) r[i*8 +: 8] = disp[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("count", 88'(count), 88'(line.size()));
        check("full", 88'(full), 88'(line.size() == LEN));
        check("overflow", 88'(overflow), 88'(m_ovf));
        check("character", dut_chars(), model_chars());
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input bit v, input logic [7:0] d, input bit vs);
        in_valid   = v;
        in_data    = d;
        vsync_tick = vs;
        #1;
        last_rdy = in_ready;
        check("in_ready", 88'(in_ready), 88'(m_rdy && !(vs && m_dirty)));
        @(posedge clk);
        model_edge(v, d, vs);
        #1;
        check_model();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, 8'(s[i]), 1'b0);
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         vs;
        bit         e_rdy;
        logic [3:0] e_count;
        bit         e_full;
        bit         e_ovf;
        logic [7:0] e_c0;
        logic [7:0] e_c2;
    } vec_t;

    vec_t vecs [16];

    logic [87:0] exp_line;

    initial begin
        vecs[0]  = '{1, 8'h41, 0, 1, 4'd1, 0, 0, 8'h00, 8'h00};
        vecs[1]  = '{1, 8'h31, 0, 1, 4'd2, 0, 0, 8'h00, 8'h00};
        vecs[2]  = '{1, 8'h5A, 0, 1, 4'd3, 0, 0, 8'h00, 8'h00};
        vecs[3]  = '{0, 8'h00, 1, 0, 4'd3, 0, 0, 8'h41, 8'h5A};
        vecs[4]  = '{0, 8'h00, 1, 1, 4'd3, 0, 0, 8'h41, 8'h5A};
        vecs[5]  = '{1, 8'h2E, 0, 1, 4'd3, 0, 0, 8'h41, 8'h5A};
        vecs[6]  = '{1, 8'h08, 0, 1, 4'd2, 0, 0, 8'h41, 8'h5A};
        vecs[7]  = '{0, 8'h00, 1, 0, 4'd2, 0, 0, 8'h41, 8'h00};
        vecs[8]  = '{1, 8'h0D, 0, 1, 4'd0, 0, 0, 8'h41, 8'h00};
        vecs[9]  = '{0, 8'h00, 1, 0, 4'd0, 0, 0, 8'h00, 8'h00};
        vecs[10] = '{1, 8'h40, 0, 1, 4'd0, 0, 0, 8'h00, 8'h00};
        vecs[11] = '{1, 8'h5B, 0, 1, 4'd0, 0, 0, 8'h00, 8'h00};
        vecs[12] = '{1, 8'h2F, 0, 1, 4'd0, 0, 0, 8'h00, 8'h00};
        vecs[13] = '{1, 8'h3A, 0, 1, 4'd0, 0, 0, 8'h00, 8'h00};
        vecs[14] = '{1, 8'h30, 0, 1, 4'd1, 0, 0, 8'h00, 8'h00};
        vecs[15] = '{1, 8'h39, 0, 1, 4'd2, 0, 0, 8'h00, 8'h00};

        // ---------------- reset ----------------
        model_reset();
        #2;
        check("rst_in_ready", 88'(in_ready), 88'(0));
        check_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 8'h00, 0);

        // ---------------- table vectors (typing + commit, class bounds) ----------------
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].vs);
            check($sformatf("vec%0d_rdy", i), 88'(last_rdy), 88'(vecs[i].e_rdy));
            check($sformatf("vec%0d_count", i), 88'(count), 88'(vecs[i].e_count));
            check($sformatf("vec%0d_full", i), 88'(full), 88'(vecs[i].e_full));
            check($sformatf("vec%0d_ovf", i), 88'(overflow), 88'(vecs[i].e_ovf));
            check($sformatf("vec%0d_c0", i), 88'(character[0]), 88'(vecs[i].e_c0));
            check($sformatf("vec%0d_c2", i), 88'(character[2]), 88'(vecs[i].e_c2));
        end

        // ---------------- typing and commit, full line compare ----------------
        step(1, 8'h0D, 0);
        step(0, 8'h00, 1);
        send_str("A1Z");
        check("pre_commit_chars", dut_chars(), 88'h0);
        step(0, 8'h00, 1);
        exp_line = 88'h0;
        exp_line[7:0] = 8'h41; exp_line[15:8] = 8'h31; exp_line[23:16] = 8'h5A;
        check("commit_A1Z", dut_chars(), exp_line);
        check("commit_A1Z_count", 88'(count), 88'(3));

        // ---------------- overflow ----------------
        step(1, 8'h0D, 0);
        send_str("0123456789AB");
        check("ovf_full", 88'(full), 88'(1));
        check("ovf_count", 88'(count), 88'(11));
        check("ovf_flag", 88'(overflow), 88'(1));
        step(0, 8'h00, 1);
        check("ovf_slot10", 88'(character[10]), 88'(8'h41));
        step(1, 8'h0D, 0);
        check("cr_count", 88'(count), 88'(0));
        check("cr_ovf", 88'(overflow), 88'(0));
        check("cr_full", 88'(full), 88'(0));

        // ---------------- backspace ----------------
        step(1, 8'h08, 0);
        check("bs_empty", 88'(count), 88'(0));
        send_str("7");
        step(1, 8'h08, 0);
        send_str("8");
        step(0, 8'h00, 1);
        exp_line = 88'h0;
        exp_line[7:0] = 8'h38;
        check("bs_chars", dut_chars(), exp_line);
        check("bs_count", 88'(count), 88'(1));

        // ---------------- simultaneous vsync and offer ----------------
        step(1, 8'h0D, 0);
        send_str("X");
        step(1, 8'h35, 1);
        check("sim_ready_low", 88'(last_rdy), 88'(0));
        check("sim_not_taken", 88'(count), 88'(1));
        step(1, 8'h35, 0);
        check("sim_ready_high", 88'(last_rdy), 88'(1));
        check("sim_taken", 88'(count), 88'(2));
        step(0, 8'h00, 1);
        check("sim_c1", 88'(character[1]), 88'(8'h35));

        // ---------------- lowercase handling ----------------
        step(1, 8'h0D, 0);
        step(0, 8'h00, 1);
        step(1, 8'h71, 0);
`ifdef LOWERCASE_FOLD_EN
        check("lc_count", 88'(count), 88'(1));
        step(0, 8'h00, 1);
        check("lc_c0", 88'(character[0]), 88'(8'h51));
`else
        check("lc_count", 88'(count), 88'(0));
        step(0, 8'h00, 1);
        check("lc_c0", 88'(character[0]), 88'(8'h00));
`endif

        // ---------------- randomized run against the model ----------------
        for (int n = 0; n < 400; n++) begin
            logic [7:0] d;
            int sel;
            sel = $urandom_range(0, 19);
            if (sel < 6)       d = 8'($urandom_range(8'h30, 8'h39));
            else if (sel < 11) d = 8'($urandom_range(8'h41, 8'h5A));
            else if (sel < 13) d = 8'h08;
            else if (sel < 14) d = 8'h0D;
            else if (sel < 16) d = 8'($urandom_range(8'h61, 8'h7A));
            else               d = 8'($urandom_range(0, 255));
            step(bit'($urandom_range(0, 3) != 0), d, bit'($urandom_range(0, 5) == 0));
        end

        // ---------------- asynchronous reset mid-line ----------------
        step(1, 8'h0D, 0);
        step(0, 8'h00, 1);
        send_str("BC");
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_chars", dut_chars(), 88'h0);
        check("arst_count", 88'(count), 88'(0));
        check("arst_full", 88'(full), 88'(0));
        check("arst_ovf", 88'(overflow), 88'(0));
        check("arst_ready", 88'(in_ready), 88'(0));
        vsync_tick = 1'b1;
        @(posedge clk);
        #1;
        vsync_tick = 1'b0;
        rst_n = 1'b1;
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        check("arst_no_commit", dut_chars(), 88'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_line_buffer.md
TEXT_LINE_BUFFER -- requirements
Module: text_line_buffer

Interface
REQ-001 The block SHALL have parameter LINE_LEN, default 11, giving the number of character slots; it is fixed at 11 to match the glyph renderer.
REQ-002 The block SHALL have port clk, input, 1 bit: the single pixel-domain clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an ASCII byte is offered on in_data.
REQ-005 The block SHALL have port in_data, input, 8 bits: the offered ASCII byte.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 The block SHALL have port vsync_tick, input, 1 bit: a one-cycle pulse at the start of vertical blanking.
REQ-008 The block SHALL have port character, output, unpacked array [0:LINE_LEN-1] of 8 bits: the displayed line; 8'h00 means an empty slot.
REQ-009 The block SHALL have port count, output, 4 bits: the number of valid characters in the working line.
REQ-010 The block SHALL have port full, output, 1 bit: count equals LINE_LEN.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag set when a printable byte is dropped because the line is full.

Function
REQ-012 A byte SHALL be accepted only on a clk rising edge where in_valid and in_ready are both 1.
REQ-013 Accepted bytes SHALL be classified as follows:
- printable: 0x30-0x39 or 0x41-0x5A
- BS: 0x08
- CR: 0x0D
- other: any remaining value, which is consumed and ignored
REQ-014 A printable byte with count<LINE_LEN SHALL be written to work[count], count SHALL increment, and dirty SHALL be set, all in the same edge.
REQ-015 A printable byte with count==LINE_LEN SHALL be dropped, set overflow, and leave dirty unchanged.
REQ-016 BS with count>0 SHALL clear work[count-1] to 0x00, decrement count, and set dirty; BS with count==0 SHALL be a no-op.
REQ-017 CR SHALL zero all work slots, set count to 0, clear overflow, and set dirty.
REQ-018 The FSM SHALL have states EMPTY (count==0), EDIT (0<count<LINE_LEN) and FULL (count==LINE_LEN).
- Transitions SHALL follow count after every accepted byte.
- CR SHALL return to EMPTY from any state.
REQ-019 On a vsync_tick cycle with dirty=1, the block SHALL perform a commit: character is copied from work on that edge and dirty is cleared.
REQ-020 The character output SHALL change only on commit edges, so it never tears mid-frame.
REQ-021 in_ready SHALL be 0 in a commit cycle and 1 in all other cycles.
- A byte offered during a commit cycle SHALL be held by the source and accepted on the next cycle.
REQ-022 A vsync_tick with dirty=0 SHALL cause no change and SHALL leave in_ready at 1.
REQ-023 count, full and overflow SHALL reflect the working line, with no latency after the accepting edge.
REQ-024 The display latency from accepting a byte to the character update SHALL be the next vsync_tick strictly after the accepting edge.

Reset
REQ-025 Asserting rst_n low SHALL asynchronously set the following, regardless of any operation in progress:
- all work and character slots to 0x00
- count=0, full=0, overflow=0, dirty=0
- state EMPTY
REQ-026 During reset in_ready SHALL be 0; it SHALL return to 1 on the first clk edge after rst_n deasserts.

Configuration
REQ-027 Macro LOWERCASE_FOLD_EN SHALL control handling of lowercase bytes.
- Defined: bytes 0x61-0x7A are treated as printable and stored as the byte minus 0x20 (uppercase).
- Undefined: bytes 0x61-0x7A are class "other" and ignored.

Structure
REQ-028 Package text_pkg SHALL hold:
- LINE_LEN
- the ASCII constants (BS, CR, digit and letter range bounds)
- the enum typedef for FSM states
- the enum typedef for byte classes
REQ-029 Sub-module ascii_classify SHALL be purely combinational, mapping in_data to a byte class and a folded character; it carries the LOWERCASE_FOLD_EN dependence.

Verification
REQ-030 Bench scenario, typing and commit: send "A","1","Z", then pulse vsync_tick.
- Required: character[0:2]=41,31,5A; slots 3-10 = 00; count=3.
- Required: character unchanged before the pulse.
REQ-031 Bench scenario, overflow: send 12 printable bytes.
- Required: full=1, count=11, overflow=1, and the 12th byte is absent after commit.
- Then send CR: count=0 and overflow=0.
REQ-032 Bench scenario, backspace: send BS on an empty line, which must be a no-op; then send "7", BS, "8" and commit.
- Required: character[0]=38, count=1.
REQ-033 Bench scenario, simultaneous events: hold in_valid with "5" during a dirty vsync_tick.
- Required: in_ready=0 in that cycle, and the byte is accepted the next cycle.
- Required: after the following vsync_tick, character[1] holds 35.
REQ-034 Bench scenario, reset mid-operation: drop rst_n asynchronously mid-line with dirty=1.
- Required: all outputs zero immediately, with no commit on the later vsync_tick.
REQ-035 Bench scenario, configuration: send "q" with LOWERCASE_FOLD_EN defined and with it undefined.
- Required with macro defined: character[0]=51 after commit.
- Required with macro undefined: the byte is ignored and count=0.
